// File: rtl/pio_debounced_pkg.sv
// Shared constants for the debounced PIO block.
//   - Register word offsets on the Avalon-MM slave.
//   - Edge-capture trigger selectors.
//   - clog2 helper for sizing counters from parameters.
package pio_debounced_pkg;

  localparam logic [2:0] REG_IN   = 3'd0;
  localparam logic [2:0] REG_OUT  = 3'd1;
  localparam logic [2:0] REG_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE = 3'd3;
  localparam logic [2:0] REG_SET  = 3'd4;
  localparam logic [2:0] REG_CLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a stability counter.
// A change on the synchronised input is accepted into stable_o only after it
// has held for DEBOUNCE_CYCLES consecutive clocks; shorter glitches are dropped.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   raw_i    - asynchronous raw input
//   stable_o - debounced level
module pio_debounce_bit
  import pio_debounced_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned CntW = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/pio_debounced_irq.sv
// Combined switch/LED PIO on one Avalon-MM slave.
// Inputs are synchronised and debounced per bit, edges are captured into a
// write-1-to-clear register, and a maskable registered level interrupt is
// raised. Outputs are a plain register with atomic set/clear aliases.
// Ports:
//   clk_clk, reset_reset             - clock, synchronous active-high reset
//   avs_*                            - Avalon-MM slave, fixed read latency 1
//   sw_external_connection_export    - raw asynchronous inputs
//   led_external_connection_export   - output register
//   irq                              - level interrupt
module pio_debounced_irq
  import pio_debounced_pkg::*;
#(
  parameter int unsigned      IN_W            = 4,
  parameter int unsigned      OUT_W           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_MODE       = 2,
  parameter logic [OUT_W-1:0] OUT_RESET       = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  input  logic [IN_W-1:0]  sw_external_connection_export,
  output logic [OUT_W-1:0] led_external_connection_export,
  output logic             irq
);

  logic [IN_W-1:0]  stable, stable_dly_q;
  logic [IN_W-1:0]  rise, fall, edge_evt, edge_clr;
  logic [IN_W-1:0]  edge_cap_q, edge_cap_d;
  logic [IN_W-1:0]  mask_q, mask_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [31:0]      rd_mux, readdata_q;
  logic             rdvalid_q, irq_q;

  // Upper writedata bits are ignored for narrow configurations.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < IN_W; i++) begin : g_in
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .raw_i   (sw_external_connection_export[i]),
      .stable_o(stable[i])
    );
  end

  assign rise = stable & ~stable_dly_q;
  assign fall = ~stable & stable_dly_q;

  always_comb begin
    if (EDGE_MODE == EDGE_RISE) begin
      edge_evt = rise;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_evt = fall;
    end else begin
      edge_evt = rise | fall;
    end
  end

  // Register writes.
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    edge_clr = '0;
    if (avs_write) begin
      case (avs_address)
        REG_OUT:  out_d    = avs_writedata[OUT_W-1:0];
        REG_MASK: mask_d   = avs_writedata[IN_W-1:0];
        REG_EDGE: edge_clr = avs_writedata[IN_W-1:0];
        REG_SET:  out_d    = out_q | avs_writedata[OUT_W-1:0];
        REG_CLR:  out_d    = out_q & ~avs_writedata[OUT_W-1:0];
        default:  ;
      endcase
    end
    // A new edge beats a same-cycle W1C on the same bit.
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_evt;
  end

  // Read mux samples current register state, so a same-cycle write or
  // capture is not yet visible.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_IN:   rd_mux[IN_W-1:0]  = stable;
      REG_OUT:  rd_mux[OUT_W-1:0] = out_q;
      REG_MASK: rd_mux[IN_W-1:0]  = mask_q;
      REG_EDGE: rd_mux[IN_W-1:0]  = edge_cap_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable_dly_q <= '0;
      edge_cap_q   <= '0;
      mask_q       <= '0;
      out_q        <= OUT_RESET;
      readdata_q   <= '0;
      rdvalid_q    <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      edge_cap_q   <= edge_cap_d;
      mask_q       <= mask_d;
      out_q        <= out_d;
      readdata_q   <= avs_read ? rd_mux : 32'd0;
      rdvalid_q    <= avs_read;
      irq_q        <= |(edge_cap_q & mask_q);
    end
  end

  assign avs_readdata                   = readdata_q;
  assign avs_readdatavalid              = rdvalid_q;
  assign irq                            = irq_q;
  assign led_external_connection_export = out_q;

endmodule

// File: tb/tb_pio_debounced_irq.sv
// Scoreboard bench: reads push expected data with the cycle it must appear;
// a monitor pops and compares whenever a DUT asserts avs_readdatavalid.
// dut 0: EDGE_MODE=2, OUT_RESET=5. dut 1: EDGE_MODE=0, OUT_RESET=0.
module tb_pio_debounced_irq;

  typedef struct {
    int          idx;
    logic [31:0] v;
    int          c;
    string       n;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr [2];
  logic [1:0]  rd, wr;
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  rvalid, irq;
  logic [3:0]  sw [2];
  logic [3:0]  led [2];

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  item_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pio_debounced_irq #(
    .IN_W(4), .OUT_W(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .OUT_RESET(4'h5)
  ) dut0 (
    .clk_clk                       (clk),
    .reset_reset                   (reset),
    .avs_address                   (addr[0]),
    .avs_read                      (rd[0]),
    .avs_write                     (wr[0]),
    .avs_writedata                 (wdata[0]),
    .avs_readdata                  (rdata[0]),
    .avs_readdatavalid             (rvalid[0]),
    .sw_external_connection_export (sw[0]),
    .led_external_connection_export(led[0]),
    .irq                           (irq[0])
  );

  pio_debounced_irq #(
    .IN_W(4), .OUT_W(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .OUT_RESET(4'h0)
  ) dut1 (
    .clk_clk                       (clk),
    .reset_reset                   (reset),
    .avs_address                   (addr[1]),
    .avs_read                      (rd[1]),
    .avs_write                     (wr[1]),
    .avs_writedata                 (wdata[1]),
    .avs_readdata                  (rdata[1]),
    .avs_readdatavalid             (rvalid[1]),
    .sw_external_connection_export (sw[1]),
    .led_external_connection_export(led[1]),
    .irq                           (irq[1])
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_reg(input int idx, input logic [2:0] a, input logic [31:0] e,
                        input string n);
    item_t it;
    it.idx = idx; it.v = e; it.c = cyc + 1; it.n = n;
    addr[idx] = a;
    rd[idx]   = 1'b1;
    sbq.push_back(it);
    tick();
    rd[idx] = 1'b0;
  endtask

  task automatic wr_reg(input int idx, input logic [2:0] a, input logic [31:0] d);
    addr[idx]  = a;
    wdata[idx] = d;
    wr[idx]    = 1'b1;
    tick();
    wr[idx] = 1'b0;
  endtask

  // Read and write the same register in one cycle.
  task automatic rdwr_reg(input int idx, input logic [2:0] a, input logic [31:0] d,
                          input logic [31:0] e, input string n);
    item_t it;
    it.idx = idx; it.v = e; it.c = cyc + 1; it.n = n;
    addr[idx]  = a;
    wdata[idx] = d;
    rd[idx]    = 1'b1;
    wr[idx]    = 1'b1;
    sbq.push_back(it);
    tick();
    rd[idx] = 1'b0;
    wr[idx] = 1'b0;
  endtask

  // Monitor
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (rvalid[d]) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rdvalid dut%0d: got data %0h, required no valid",
                     d, rdata[d]);
          end else begin
            it = sbq.pop_front();
            chk({it.n, "_dut"}, 32'(d), 32'(it.idx));
            chk(it.n, rdata[d], it.v);
            chk({it.n, "_cycle"}, 32'(cyc), 32'(it.c));
          end
        end
      end
    end
  end

  logic [31:0] rst_exp [8];

  initial begin
    reset = 1'b1;
    rd = '0; wr = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; sw[d] = '0;
    end
    rst_exp = '{32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ticks(3);
    reset = 1'b0;

    // Reset state, all offsets.
    for (int a = 0; a < 8; a++) rd_reg(0, 3'(a), rst_exp[a], $sformatf("rst_reg%0d", a));
    chk("rst_irq", 32'(irq[0]), 32'h0);
    chk("rst_led", 32'(led[0]), 32'h5);
    chk("rst_led_dut1", 32'(led[1]), 32'h0);

    wr_reg(0, 3'd2, 32'h5);
    rd_reg(0, 3'd2, 32'h5, "mask_rb");

    // 3-cycle glitch on bit 2 must be filtered.
    sw[0][2] = 1'b1;
    ticks(3);
    sw[0][2] = 1'b0;
    ticks(10);
    rd_reg(0, 3'd0, 32'h0, "glitch_in");
    rd_reg(0, 3'd3, 32'h0, "glitch_edge");
    chk("glitch_irq", 32'(irq[0]), 32'h0);

    // Held rise on bit 0: stable after 6 clocks, edge after 7, irq after 8.
    sw[0][0] = 1'b1;
    ticks(5);
    rd_reg(0, 3'd0, 32'h0, "rise_in_e6");
    rd_reg(0, 3'd0, 32'h1, "rise_in_e7");
    chk("rise_irq_e7", 32'(irq[0]), 32'h0);
    rd_reg(0, 3'd3, 32'h1, "rise_edge_e8");
    chk("rise_irq_e8", 32'(irq[0]), 32'h1);

    // Output register, set, clear.
    wr_reg(0, 3'd1, 32'hA);
    chk("led_write", 32'(led[0]), 32'hA);
    wr_reg(0, 3'd4, 32'h1);
    chk("led_set", 32'(led[0]), 32'hB);
    wr_reg(0, 3'd5, 32'h8);
    chk("led_clr", 32'(led[0]), 32'h3);
    rd_reg(0, 3'd1, 32'h3, "out_rb");
    rd_reg(0, 3'd4, 32'h0, "set_rb");
    rd_reg(0, 3'd5, 32'h0, "clr_rb");
    rdwr_reg(0, 3'd1, 32'hC, 32'h3, "rdwr_prewrite");
    rd_reg(0, 3'd1, 32'hC, "rdwr_post");
    wr_reg(0, 3'd6, 32'hF);
    rd_reg(0, 3'd6, 32'h0, "reserved_rb");

    // Falling edge on bit 0 captured in the same cycle as a W1C of bit 0.
    sw[0][0] = 1'b0;
    ticks(6);
    wr_reg(0, 3'd3, 32'h1);
    chk("w1c_race_irq_a", 32'(irq[0]), 32'h1);
    rd_reg(0, 3'd3, 32'h1, "w1c_race_edge");
    chk("w1c_race_irq_b", 32'(irq[0]), 32'h1);
    wr_reg(0, 3'd3, 32'h1);
    chk("w1c_irq_lag", 32'(irq[0]), 32'h1);
    tick();
    chk("w1c_irq_clear", 32'(irq[0]), 32'h0);
    rd_reg(0, 3'd3, 32'h0, "w1c_edge_clear");
    rd_reg(0, 3'd0, 32'h0, "fall_in");

    // Rising-only mode on dut1.
    sw[1][1] = 1'b1;
    ticks(10);
    sw[1][1] = 1'b0;
    ticks(10);
    rd_reg(1, 3'd3, 32'h2, "risemode_edge");
    rd_reg(1, 3'd0, 32'h0, "risemode_in");
    chk("risemode_irq", 32'(irq[1]), 32'h0);
    wr_reg(1, 3'd3, 32'h2);
    wr_reg(1, 3'd1, 32'h9);
    wr_reg(1, 3'd2, 32'hF);
    rd_reg(1, 3'd3, 32'h0, "risemode_clr");

    // Reset mid-debounce, with a read in the reset cycle (no valid expected).
    sw[1][1] = 1'b1;
    ticks(3);
    addr[1] = 3'd0;
    rd[1]   = 1'b1;
    reset   = 1'b1;
    sw[1]   = '0;
    tick();
    rd[1] = 1'b0;
    tick();
    reset = 1'b0;
    ticks(10);
    rd_reg(1, 3'd0, 32'h0, "midrst_in");
    rd_reg(1, 3'd1, 32'h0, "midrst_out");
    rd_reg(1, 3'd2, 32'h0, "midrst_mask");
    rd_reg(1, 3'd3, 32'h0, "midrst_edge");
    chk("midrst_irq", 32'(irq[1]), 32'h0);
    chk("midrst_led1", 32'(led[1]), 32'h0);
    chk("midrst_led0", 32'(led[0]), 32'h5);

    ticks(3);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
